atomic_sequencer: RTL and testbench
===================================

# atomic_sequencer

Multi-cycle controller that executes RV32A/RV64A atomic instructions (LR, SC, AMO*) for the memory stage. It sequences the data-memory port through read / modify / write phases and drives the LR/SC reservation tracker through its `lr_*` and `sc_*` inputs. It samples `sc_success` from the tracker and returns the destination-register value to the pipeline. The pipeline stalls while `ready` is low.

## Interface
- `XLEN`, 32: data/address width; accesses are XLEN-wide only (word on RV32, doubleword on RV64).
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: launch atomic; accepted only when `ready`=1.
- `funct5` in 5: AMO funct5 (ADD 00000, SWAP 00001, LR 00010, SC 00011, XOR 00100, OR 01000, AND 01100, MIN 10000, MAX 10100, MINU 11000, MAXU 11100).
- `addr` in XLEN: effective address (rs1).
- `src` in XLEN: rs2 operand.
- `flush` in 1: pipeline flush / trap abort.
- `ready` out 1: idle, can accept `start`.
- `done` out 1: one-cycle pulse, `result` valid.
- `result` out XLEN: rd write value.
- `illegal` out 1: with `done`, unsupported funct5.
- `misaligned` out 1: with `done`, address not XLEN/8-aligned.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1=write.
- `mem_addr` out XLEN: access address.
- `mem_wdata` out XLEN: write data.
- `mem_ready` in 1: request accepted/completed this cycle.
- `mem_rdata` in XLEN: read data, valid when `mem_req && !mem_we && mem_ready`.
- `lr_valid` out 1: one-cycle pulse to reservation tracker.
- `lr_addr` out XLEN: reserved address.
- `sc_valid` out 1: one-cycle pulse to reservation tracker.
- `sc_addr` out XLEN: SC address.
- `sc_success` in 1: combinational tracker response, sampled in the `sc_valid` cycle.

## Operation
- States: IDLE, READ, WRITE, SC_CHK, DONE.
- IDLE: `ready`=1. On `start`, latch `funct5`/`addr`/`src`.
  - Misaligned or illegal → DONE with the matching flag.
  - SC → SC_CHK.
  - Otherwise → READ.
- READ: `mem_req`=1, `mem_we`=0, `mem_addr`=latched addr; held until `mem_ready`. On `mem_ready`, capture `mem_rdata` as old value.
  - LR: pulse `lr_valid` (`lr_addr`=addr) in the same cycle, `result`=old, → DONE.
  - AMO: compute new value, → WRITE.
- WRITE: `mem_req`=1, `mem_we`=1, `mem_wdata`=new value; held until `mem_ready`, then → DONE.
- SC_CHK: one cycle; pulse `sc_valid` (`sc_addr`=addr) and sample `sc_success`.
  - 1 → WRITE with `mem_wdata`=src, `result`=0.
  - 0 → DONE, `result`=1, no memory access.
- AMO result = old memory value; new value per op:
  - ADD: modulo 2^XLEN.
  - XOR, OR, AND: bitwise.
  - SWAP: src.
  - MIN/MAX: signed compare.
  - MINU/MAXU: unsigned compare.
- DONE: `done`=1 for one cycle → IDLE. `result` holds its value until the next `done`.
- `flush` in READ or SC_CHK: → IDLE immediately. No `done`, no `lr_valid`/`sc_valid` pulse in that cycle, `mem_req` drops.
- `flush` in WRITE: ignored. The write completes and `done` is still pulsed, so a store is never torn.
- `flush` in DONE: `done` suppressed.
- Reset mid-operation: → IDLE, all requests drop.
- Reset values: state IDLE, `ready`=1; `done`, `illegal`, `misaligned`, `mem_req`, `mem_we`, `lr_valid`, `sc_valid`=0; all buses 0.

## Timing
- Zero-wait memory (`mem_ready` held 1); `start` accepted at cycle 0:
  - LR: `done` at cycle 2.
  - AMO: `done` at cycle 3.
  - SC success: `done` at cycle 3.
  - SC fail: `done` at cycle 2.
  - Illegal/misaligned: `done` at cycle 1.
- Each memory wait cycle adds one cycle.
- `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1.
- `ready` is low from the cycle after acceptance through the DONE cycle.

## Configuration
- `RV_AMO_MINMAX_EN` defined: MIN, MAX, MINU and MAXU are executed.
- Not defined: those four funct5 codes are illegal. They produce `done` + `illegal` at cycle 1 with no memory access, and the comparator logic is absent.

## Test plan
- AMOADD, mem[0x100]=5, src=3, zero-wait → read 0x100, write 8, `result`=5, `done` at cycle 3.
- LR 0x200 then SC 0x200 with src=0xAB, tracker reserved → `lr_valid` pulse; SC writes 0xAB, `result`=0. Repeat the SC without a new LR → `result`=1, no write.
- AMOMAXU, mem=0xFFFFFFFF, src=1 → write 0xFFFFFFFF. AMOMAX with the same values → write 1 (`RV_AMO_MINMAX_EN` defined). Macro undefined → `illegal`=1, `mem_req` never asserted.
- AMOSWAP at 0x102 (RV32) → `misaligned`=1 at cycle 1, no `mem_req`.
- AMOOR with `mem_ready` low for 3 cycles in READ → request held stable, `done` at cycle 6.
- `flush` during a READ wait → IDLE next cycle, no `done`, no write. `flush` during WRITE → write completes, `done` asserted.

Source files
------------

// File: rtl/atomic_sequencer_if.sv
// atomic_sequencer_if: pipeline, data-memory and reservation-tracker signals
// of the atomic sequencer. The slave modport is the sequencer's view; the
// master modport is the view of the surrounding pipeline/memory/tracker.
interface atomic_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  // Pipeline side
  logic            start;
  logic [4:0]      funct5;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] src;
  logic            flush;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] result;
  logic            illegal;
  logic            misaligned;
  // Data-memory port
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;
  // Reservation tracker
  logic            lr_valid;
  logic [XLEN-1:0] lr_addr;
  logic            sc_valid;
  logic [XLEN-1:0] sc_addr;
  logic            sc_success;

  modport slave (
    input  start, funct5, addr, src, flush, mem_ready, mem_rdata, sc_success,
    output ready, done, result, illegal, misaligned,
           mem_req, mem_we, mem_addr, mem_wdata,
           lr_valid, lr_addr, sc_valid, sc_addr
  );

  modport master (
    output start, funct5, addr, src, flush, mem_ready, mem_rdata, sc_success,
    input  ready, done, result, illegal, misaligned,
           mem_req, mem_we, mem_addr, mem_wdata,
           lr_valid, lr_addr, sc_valid, sc_addr
  );
endinterface

// File: rtl/atomic_sequencer.sv
// atomic_sequencer: multi-cycle RV32A/RV64A atomic controller (LR, SC, AMO*).
// Sequences the data-memory port through read/modify/write, drives the LR/SC
// reservation tracker and returns the rd value to the pipeline.
// Build option: define RV_AMO_MINMAX_EN to execute AMOMIN/MAX/MINU/MAXU;
// otherwise those encodings are reported as illegal.
module atomic_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  atomic_sequencer_if.slave  bus
);

  localparam int unsigned OFFW = $clog2(XLEN / 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_SC_CHK,
    S_DONE
  } state_e;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SWAP = 5'b00001,
    OP_LR   = 5'b00010,
    OP_SC   = 5'b00011,
    OP_XOR  = 5'b00100,
    OP_OR   = 5'b01000,
    OP_AND  = 5'b01100,
    OP_MIN  = 5'b10000,
    OP_MAX  = 5'b10100,
    OP_MINU = 5'b11000,
    OP_MAXU = 5'b11100
  } amo_op_e;

  state_e          state_q, state_d;
  logic [4:0]      op_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] src_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] pend_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] amo_new;
  logic            ill_q;
  logic            mis_q;

  logic            start_ill;
  logic            start_mis;
  logic            accept;
  logic            rd_capture;
  logic            ready_int;
  logic            done_int;
  logic            mem_req_int;
  logic            mem_we_int;
  logic            lr_pulse;
  logic            sc_pulse;

  assign start_mis = |bus.addr[OFFW-1:0];

  // Decode whether the incoming funct5 is a supported atomic
  always_comb begin
    start_ill = 1'b1;
    case (bus.funct5)
      OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND: start_ill = 1'b0;
`ifdef RV_AMO_MINMAX_EN
      OP_MIN, OP_MAX, OP_MINU, OP_MAXU:                     start_ill = 1'b0;
`endif
      default:                                              start_ill = 1'b1;
    endcase
  end

  // New memory value from the old value (live read data) and rs2
  always_comb begin
    amo_new = src_q;
    case (op_q)
      OP_ADD:  amo_new = bus.mem_rdata + src_q;
      OP_XOR:  amo_new = bus.mem_rdata ^ src_q;
      OP_OR:   amo_new = bus.mem_rdata | src_q;
      OP_AND:  amo_new = bus.mem_rdata & src_q;
`ifdef RV_AMO_MINMAX_EN
      OP_MIN:  amo_new = ($signed(bus.mem_rdata) < $signed(src_q)) ? bus.mem_rdata : src_q;
      OP_MAX:  amo_new = ($signed(bus.mem_rdata) > $signed(src_q)) ? bus.mem_rdata : src_q;
      OP_MINU: amo_new = (bus.mem_rdata < src_q) ? bus.mem_rdata : src_q;
      OP_MAXU: amo_new = (bus.mem_rdata > src_q) ? bus.mem_rdata : src_q;
`endif
      default: amo_new = src_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs; flush gates every pulse combinationally
  always_comb begin
    state_d     = state_q;
    ready_int   = 1'b0;
    done_int    = 1'b0;
    mem_req_int = 1'b0;
    mem_we_int  = 1'b0;
    lr_pulse    = 1'b0;
    sc_pulse    = 1'b0;
    accept      = 1'b0;
    rd_capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_int = 1'b1;
        if (bus.start) begin
          accept = 1'b1;
          if (start_mis || start_ill) state_d = S_DONE;
          else if (bus.funct5 == OP_SC) state_d = S_SC_CHK;
          else                          state_d = S_READ;
        end
      end
      S_READ: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          mem_req_int = 1'b1;
          if (bus.mem_ready) begin
            rd_capture = 1'b1;
            if (op_q == OP_LR) begin
              lr_pulse = 1'b1;
              state_d  = S_DONE;
            end else begin
              state_d  = S_WRITE;
            end
          end
        end
      end
      S_WRITE: begin
        mem_req_int = 1'b1;
        mem_we_int  = 1'b1;
        if (bus.mem_ready) state_d = S_DONE;
      end
      S_SC_CHK: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          sc_pulse = 1'b1;
          state_d  = bus.sc_success ? S_WRITE : S_DONE;
        end
      end
      S_DONE: begin
        done_int = ~bus.flush;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latches, pending rd value and write data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      addr_q   <= '0;
      src_q    <= '0;
      wdata_q  <= '0;
      pend_q   <= '0;
      result_q <= '0;
      ill_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= bus.funct5;
        addr_q <= bus.addr;
        src_q  <= bus.src;
        ill_q  <= start_ill;
        mis_q  <= start_mis;
        pend_q <= '0;
      end
      if (rd_capture) begin
        pend_q  <= bus.mem_rdata;
        wdata_q <= amo_new;
      end
      if (sc_pulse) begin
        if (bus.sc_success) begin
          wdata_q <= src_q;
          pend_q  <= '0;
        end else begin
          pend_q  <= XLEN'(1);
        end
      end
      if (done_int) result_q <= pend_q;
    end
  end

  // The pending value is only exposed with done, so result stays put between dones
  assign bus.result     = done_int ? pend_q : result_q;
  assign bus.ready      = ready_int;
  assign bus.done       = done_int;
  assign bus.illegal    = done_int & ill_q;
  assign bus.misaligned = done_int & mis_q;
  assign bus.mem_req    = mem_req_int;
  assign bus.mem_we     = mem_we_int;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.lr_valid   = lr_pulse;
  assign bus.lr_addr    = addr_q;
  assign bus.sc_valid   = sc_pulse;
  assign bus.sc_addr    = addr_q;

endmodule

// File: tb/tb_atomic_sequencer.sv
// tb_atomic_sequencer: randomized and directed checks of atomic_sequencer
// against a transaction-level reference model (memory array + reservation).
module tb_atomic_sequencer;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

`ifdef RV_AMO_MINMAX_EN
  localparam bit MINMAX = 1'b1;
`else
  localparam bit MINMAX = 1'b0;
`endif

  logic clk;
  logic reset;

  atomic_sequencer_if #(.XLEN(32)) bus ();

  atomic_sequencer #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- environment: memory + reservation tracker ----------------
  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];
  int unsigned rd_wait = 0, wr_wait = 0, wcnt = 0;
  logic        poke_en = 1'b0;
  logic [31:0] poke_a = '0, poke_d = '0;
  logic        resv_v = 1'b0;
  logic [31:0] resv_a = '0;
  int rd_cnt = 0, wr_cnt = 0, lr_cnt = 0, sc_cnt = 0, done_cnt = 0, req_cyc = 0, stab_err = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;
  logic        prev_pend = 1'b0, p_we = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;

  always_comb begin
    bus.mem_ready  = bus.mem_req && (wcnt >= (bus.mem_we ? wr_wait : rd_wait));
    bus.mem_rdata  = env_mem[bus.mem_addr[9:2]];
    bus.sc_success = resv_v && (resv_a == bus.sc_addr);
  end

  always @(posedge clk) begin
    if (poke_en) env_mem[poke_a[9:2]] <= poke_d;
    if (reset) begin
      wcnt      <= 0;
      prev_pend <= 1'b0;
    end else begin
      wcnt <= (bus.mem_req && !bus.mem_ready) ? wcnt + 1 : 0;
      if (bus.mem_req) req_cyc <= req_cyc + 1;
      if (bus.mem_req && bus.mem_ready) begin
        if (bus.mem_we) begin
          env_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
          wr_cnt     <= wr_cnt + 1;
          last_waddr <= bus.mem_addr;
          last_wdata <= bus.mem_wdata;
        end else begin
          rd_cnt <= rd_cnt + 1;
        end
      end
      if (bus.lr_valid) begin
        resv_v <= 1'b1;
        resv_a <= bus.lr_addr;
        lr_cnt <= lr_cnt + 1;
      end
      if (bus.sc_valid) begin
        resv_v <= 1'b0;
        sc_cnt <= sc_cnt + 1;
      end
      if (bus.done) done_cnt <= done_cnt + 1;
      if (prev_pend && bus.mem_req &&
          (bus.mem_addr !== p_addr || bus.mem_we !== p_we || (p_we && bus.mem_wdata !== p_wdata)))
        stab_err <= stab_err + 1;
      prev_pend <= bus.mem_req && !bus.mem_ready;
      p_addr    <= bus.mem_addr;
      p_we      <= bus.mem_we;
      p_wdata   <= bus.mem_wdata;
    end
  end

  // ---------------- reference model ----------------
  bit          ref_rv = 1'b0;
  logic [31:0] ref_ra = '0;

  function automatic bit ref_legal(input logic [4:0] f);
    if (f inside {F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND}) return 1'b1;
    if (f inside {F_MIN, F_MAX, F_MINU, F_MAXU}) return MINMAX;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_amo(input logic [4:0] f, input logic [31:0] m, input logic [31:0] s);
    int signed ms, ss;
    ms = m;
    ss = s;
    case (f)
      F_ADD:   return m + s;
      F_XOR:   return m ^ s;
      F_OR:    return m | s;
      F_AND:   return m & s;
      F_MIN:   return (ms < ss) ? m : s;
      F_MAX:   return (ms > ss) ? m : s;
      F_MINU:  return (m < s) ? m : s;
      F_MAXU:  return (m > s) ? m : s;
      default: return s;
    endcase
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_a  = a;
    poke_d  = d;
    poke_en = 1'b1;
    ref_mem[a[9:2]] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // One complete atomic; flush_at>0 pulses flush for one cycle at that cycle
  task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] s,
                        input int unsigned rw, input int unsigned ww, input int unsigned flush_at);
    bit          legal, mis, chk_res, exp_wr;
    int          exp_rd, exp_lr, exp_sc, exp_lat;
    logic [31:0] old, exp_res, wval;
    int          rd0, wr0, lr0, sc0, dn0, st0, cyc;

    legal   = ref_legal(f);
    mis     = (a[1:0] != 2'b00);
    old     = ref_mem[a[9:2]];
    chk_res = 1'b1;
    exp_wr  = 1'b0;
    exp_rd  = 0;
    exp_lr  = 0;
    exp_sc  = 0;
    exp_res = '0;
    wval    = '0;
    if (!legal || mis) begin
      exp_lat = 1;
      chk_res = 1'b0;
    end else if (f == F_LR) begin
      exp_res = old;
      exp_lat = 2 + rw;
      exp_rd  = 1;
      exp_lr  = 1;
      ref_rv  = 1'b1;
      ref_ra  = a;
    end else if (f == F_SC) begin
      exp_sc = 1;
      if (ref_rv && ref_ra == a) begin
        exp_wr  = 1'b1;
        wval    = s;
        exp_res = 32'd0;
        exp_lat = 3 + ww;
      end else begin
        exp_res = 32'd1;
        exp_lat = 2;
      end
      ref_rv = 1'b0;
    end else begin
      exp_rd  = 1;
      exp_wr  = 1'b1;
      exp_res = old;
      wval    = ref_amo(f, old, s);
      exp_lat = 3 + rw + ww;
    end

    rd0 = rd_cnt; wr0 = wr_cnt; lr0 = lr_cnt; sc0 = sc_cnt; dn0 = done_cnt; st0 = stab_err;
    rd_wait = rw;
    wr_wait = ww;
    @(negedge clk);
    check("ready_idle", bus.ready, 1);
    bus.start  = 1'b1;
    bus.funct5 = f;
    bus.addr   = a;
    bus.src    = s;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    check("ready_busy", bus.ready, 0);
    while (cyc < 40) begin
      bus.flush = (flush_at != 0) && (cyc == flush_at);
      #1;
      if (bus.flush) check("flush_write_req", bus.mem_req, 1);
      if (bus.done === 1'b1) break;
      @(negedge clk);
      cyc++;
    end
    bus.flush = 1'b0;
    check("latency", cyc, exp_lat);
    check("illegal", bus.illegal, !legal);
    check("misaligned", bus.misaligned, mis);
    if (chk_res) check("result", bus.result, exp_res);
    @(negedge clk);
    check("ready_after", bus.ready, 1);
    if (chk_res) check("result_hold", bus.result, exp_res);
    check("done_pulses", done_cnt - dn0, 1);
    check("reads", rd_cnt - rd0, exp_rd);
    check("writes", wr_cnt - wr0, exp_wr);
    check("lr_pulses", lr_cnt - lr0, exp_lr);
    check("sc_pulses", sc_cnt - sc0, exp_sc);
    check("req_stable", stab_err - st0, 0);
    if (exp_wr) begin
      check("write_addr", last_waddr, a);
      check("write_data", last_wdata, wval);
      ref_mem[a[9:2]] = wval;
    end
  endtask

  // Start an op, then flush or reset it at cycle `at`; nothing must complete
  task automatic abort_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] s,
                          input int unsigned rw, input bit use_reset, input int unsigned at);
    int rd0, wr0, lr0, sc0, dn0, cyc;
    rd0 = rd_cnt; wr0 = wr_cnt; lr0 = lr_cnt; sc0 = sc_cnt; dn0 = done_cnt;
    rd_wait = rw;
    wr_wait = 0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct5 = f;
    bus.addr   = a;
    bus.src    = s;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < at) begin
      @(negedge clk);
      cyc++;
    end
    if (use_reset) reset = 1'b1;
    else           bus.flush = 1'b1;
    #1;
    check("abort_req", bus.mem_req, 0);
    check("abort_done", bus.done, 0);
    check("abort_lr", bus.lr_valid, 0);
    check("abort_sc", bus.sc_valid, 0);
    @(negedge clk);
    reset     = 1'b0;
    bus.flush = 1'b0;
    check("abort_ready", bus.ready, 1);
    if (use_reset) check("reset_result", bus.result, 0);
    repeat (6) @(negedge clk);
    check("abort_no_done", done_cnt - dn0, 0);
    check("abort_no_write", wr_cnt - wr0, 0);
    check("abort_no_read", rd_cnt - rd0, 0);
    check("abort_no_lr", lr_cnt - lr0, 0);
    check("abort_no_sc", sc_cnt - sc0, 0);
  endtask

  logic [4:0] op_tab [12];

  initial begin
    logic [4:0]  f;
    logic [31:0] a;
    int unsigned k;

    op_tab = '{F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
               F_MIN, F_MAX, F_MINU, F_MAXU, 5'b00101};
    bus.start = 1'b0; bus.funct5 = '0; bus.addr = '0; bus.src = '0; bus.flush = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_illegal", bus.illegal, 0);
    check("rst_misaligned", bus.misaligned, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_lr", bus.lr_valid, 0);
    check("rst_sc", bus.sc_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) poke(32'(i) << 2, $urandom);

    // Directed cases
    poke(32'h100, 32'd5);
    run_op(F_ADD, 32'h100, 32'd3, 0, 0, 0);
    run_op(F_LR, 32'h200, 32'd0, 0, 0, 0);
    run_op(F_SC, 32'h200, 32'hAB, 0, 0, 0);
    run_op(F_SC, 32'h200, 32'hCD, 0, 0, 0);
    poke(32'h104, 32'hFFFF_FFFF);
    run_op(F_MAXU, 32'h104, 32'd1, 0, 0, 0);
    poke(32'h104, 32'hFFFF_FFFF);
    run_op(F_MAX, 32'h104, 32'd1, 0, 0, 0);
    run_op(F_SWAP, 32'h102, 32'h1234, 0, 0, 0);
    run_op(F_OR, 32'h108, 32'hF0F0, 3, 0, 0);
    run_op(F_AND, 32'h10C, 32'h0FF0, 2, 3, 0);
    run_op(F_ADD, 32'h110, 32'h7, 0, 3, 2);
    abort_op(F_OR, 32'h114, 32'h1, 5, 1'b0, 2);
    run_op(F_LR, 32'h120, 32'd0, 1, 0, 0);
    abort_op(F_SC, 32'h120, 32'h55, 0, 1'b0, 1);
    run_op(F_SC, 32'h120, 32'h66, 0, 2, 0);
    abort_op(F_XOR, 32'h124, 32'h3, 4, 1'b1, 2);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 11);
      f = op_tab[k];
      if (f == F_LR || f == F_SC) a = 32'h300 + (32'($urandom_range(0, 3)) << 2);
      else                        a = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      run_op(f, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
